// File: rtl/mult8x8_ctrl.sv
// mult8x8_ctrl
// ------------
// Sequencer and operand datapath for the 8x8 nibble-serial multiplier.
// On start (sampled only in IDLE) the two operands are latched. The block
// then steps CLR -> LL -> LH -> HL -> HH -> DONE. In each partial-product
// state it presents one NIB_W x NIB_W product on pp_out, together with the
// shifter code and the accumulator add-enable. All outputs are Moore: they
// are decoded from the state register and the operand registers only.
//
// Optional build macro:
//   MULT_ZERO_SKIP_EN - skip any partial-product state whose selected
//                       a nibble or b nibble is zero. CLR and DONE always run.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   operation request, sampled only in IDLE
//   a, b       in   multiplicand / multiplier (2*NIB_W bits)
//   pp_out     out  current partial product (2*NIB_W bits)
//   shift_ctrl out  shifter code: 00 = <<0, 01 = <<NIB_W, 10 = <<2*NIB_W
//   acc_clr    out  accumulator clear strobe (CLR state)
//   acc_en     out  accumulator add-enable (LL..HH)
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse; the accumulator holds the final product
//   state_out  out  encoded state: IDLE=0 CLR=1 LL=2 LH=3 HL=4 HH=5 DONE=6

module mult8x8_ctrl #(
    parameter int unsigned NIB_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*NIB_W-1:0] a,
    input  logic [2*NIB_W-1:0] b,
    output logic [2*NIB_W-1:0] pp_out,
    output logic [1:0]         shift_ctrl,
    output logic               acc_clr,
    output logic               acc_en,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state_out
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LL   = 3'd2,
        ST_LH   = 3'd3,
        ST_HL   = 3'd4,
        ST_HH   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*NIB_W-1:0] a_reg;
    logic [2*NIB_W-1:0] b_reg;

    logic [NIB_W-1:0] a_lo;
    logic [NIB_W-1:0] a_hi;
    logic [NIB_W-1:0] b_lo;
    logic [NIB_W-1:0] b_hi;

    // Successor of each step in the fixed LL -> LH -> HL -> HH -> DONE order.
    state_t after_clr;
    state_t after_ll;
    state_t after_lh;
    state_t after_hl;

    // Full-width unsigned product of two nibbles; operands are widened first
    // so the product is never truncated to NIB_W bits.
    function automatic logic [2*NIB_W-1:0] nib_mul(
        input logic [NIB_W-1:0] x,
        input logic [NIB_W-1:0] y
    );
        return {{NIB_W{1'b0}}, x} * {{NIB_W{1'b0}}, y};
    endfunction

    assign a_lo = a_reg[NIB_W-1:0];
    assign a_hi = a_reg[2*NIB_W-1:NIB_W];
    assign b_lo = b_reg[NIB_W-1:0];
    assign b_hi = b_reg[2*NIB_W-1:NIB_W];

`ifdef MULT_ZERO_SKIP_EN
    logic ll_nz;
    logic lh_nz;
    logic hl_nz;
    logic hh_nz;

    always_comb begin
        ll_nz = (a_lo != '0) && (b_lo != '0);
        lh_nz = (a_lo != '0) && (b_hi != '0);
        hl_nz = (a_hi != '0) && (b_lo != '0);
        hh_nz = (a_hi != '0) && (b_hi != '0);
    end

    // Built back-to-front so each step falls through to the first later
    // step that has a non-zero product, or to DONE.
    always_comb begin
        after_hl  = hh_nz ? ST_HH : ST_DONE;
        after_lh  = hl_nz ? ST_HL : after_hl;
        after_ll  = lh_nz ? ST_LH : after_lh;
        after_clr = ll_nz ? ST_LL : after_ll;
    end
`else
    always_comb begin
        after_clr = ST_LL;
        after_ll  = ST_LH;
        after_lh  = ST_HL;
        after_hl  = ST_HH;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand registers: loaded only when a request is accepted in IDLE and
    // frozen for the rest of the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (state == ST_IDLE && start) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_CLR;
            ST_CLR:  state_nxt = after_clr;
            ST_LL:   state_nxt = after_ll;
            ST_LH:   state_nxt = after_lh;
            ST_HL:   state_nxt = after_hl;
            ST_HH:   state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        pp_out     = '0;
        shift_ctrl = 2'b00;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: busy = 1'b0;
            ST_CLR:  acc_clr = 1'b1;
            ST_LL: begin
                acc_en     = 1'b1;
                pp_out     = nib_mul(a_lo, b_lo);
                shift_ctrl = 2'b00;
            end
            ST_LH: begin
                acc_en     = 1'b1;
                pp_out     = nib_mul(a_lo, b_hi);
                shift_ctrl = 2'b01;
            end
            ST_HL: begin
                acc_en     = 1'b1;
                pp_out     = nib_mul(a_hi, b_lo);
                shift_ctrl = 2'b01;
            end
            ST_HH: begin
                acc_en     = 1'b1;
                pp_out     = nib_mul(a_hi, b_hi);
                shift_ctrl = 2'b10;
            end
            ST_DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_mult8x8_ctrl.sv
// Self-checking bench for mult8x8_ctrl. A cycle-level reference of the
// sequencer predicts every output each cycle. A downstream accumulator is
// built from the DUT strobes. A scoreboard queue holds a*b for every
// accepted request, and the queue head is compared with the accumulator on
// each done pulse. Build with +define+MULT_ZERO_SKIP_EN to exercise the
// zero-skip variant.

module tb_mult8x8_ctrl;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] pp_out;
    logic [1:0] shift_ctrl;
    logic       acc_clr;
    logic       acc_en;
    logic       busy;
    logic       done;
    logic [2:0] state_out;

    always #5 clk = ~clk;

    mult8x8_ctrl #(.NIB_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .pp_out     (pp_out),
        .shift_ctrl (shift_ctrl),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .busy       (busy),
        .done       (done),
        .state_out  (state_out)
    );

    typedef struct {
        logic [7:0]  op_a;
        logic [7:0]  op_b;
        logic [15:0] prod;
    } op_t;

    op_t        sb_q[$];
    logic [9:0] pp_log[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int clr_cnt  = 0;

    int          m_state = 0;
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;
    logic [15:0] acc = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic pp_ok(input logic [7:0] oa, input logic [7:0] ob, input int k);
        logic [3:0] an;
        logic [3:0] bn;
        an = (k >= 2) ? oa[7:4] : oa[3:0];
        bn = (k % 2 == 1) ? ob[7:4] : ob[3:0];
        return !SKIP || (an != 4'd0 && bn != 4'd0);
    endfunction

    // First partial-product step with index >= k that runs, as a state code.
    function automatic int next_from(input logic [7:0] oa, input logic [7:0] ob, input int k);
        for (int j = k; j < 4; j++) begin
            if (pp_ok(oa, ob, j)) return 2 + j;
        end
        return 6;
    endfunction

    // Reference sequencer and scoreboard producer
    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_a     <= '0;
            m_b     <= '0;
            sb_q.delete();
        end else begin
            case (m_state)
                0: if (start) begin
                    m_a <= a;
                    m_b <= b;
                    sb_q.push_back('{a, b, {8'h00, a} * {8'h00, b}});
                    m_state <= 1;
                end
                1:          m_state <= next_from(m_a, m_b, 0);
                2, 3, 4, 5: m_state <= next_from(m_a, m_b, m_state - 1);
                default:    m_state <= 0;
            endcase
        end
    end

    // Downstream accumulator driven by the DUT strobes
    always @(posedge clk) begin
        if (acc_clr)
            acc <= '0;
        else if (acc_en)
            acc <= acc + ({8'h00, pp_out} << (4 * shift_ctrl));
    end

    // Per-cycle output check and scoreboard consumer
    always @(negedge clk) begin
        logic [7:0] e_pp;
        logic [1:0] e_sh;
        e_pp = '0;
        e_sh = 2'b00;
        case (m_state)
            2: begin e_pp = {4'h0, m_a[3:0]} * {4'h0, m_b[3:0]}; e_sh = 2'b00; end
            3: begin e_pp = {4'h0, m_a[3:0]} * {4'h0, m_b[7:4]}; e_sh = 2'b01; end
            4: begin e_pp = {4'h0, m_a[7:4]} * {4'h0, m_b[3:0]}; e_sh = 2'b01; end
            5: begin e_pp = {4'h0, m_a[7:4]} * {4'h0, m_b[7:4]}; e_sh = 2'b10; end
            default: ;
        endcase
        check_val("cycle_outputs",
                  {15'd0, pp_out, shift_ctrl, acc_clr, acc_en, busy, done, state_out},
                  {15'd0, e_pp, e_sh, (m_state == 1), (m_state >= 2 && m_state <= 5),
                   (m_state != 0), (m_state == 6), 3'(m_state)});
        if (acc_clr) clr_cnt++;
        if (done) begin
            done_cnt++;
            check_val("sb_nonempty_at_done", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                check_val("product", acc, sb_q[0].prod);
                void'(sb_q.pop_front());
            end
        end
    end

    // One request from IDLE; measures edges from acceptance to done.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pp_log.delete();
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (acc_en) pp_log.push_back({pp_out, shift_ctrl});
            if (done) seen = 1'b1;
        end
        check_val("latency", lat, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] abcd_pp[4];
        int c0;
        int d0;
        int n;
        abcd_pp[0] = {8'h8F, 2'b00};
        abcd_pp[1] = {8'h84, 2'b01};
        abcd_pp[2] = {8'h82, 2'b01};
        abcd_pp[3] = {8'h78, 2'b10};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check_val("reset_outputs",
                  {pp_out, shift_ctrl, acc_clr, acc_en, busy, done, state_out}, 0);
        rst = 1'b0;

        // Main example with explicit partial products
        run_op(8'hAB, 8'hCD, 5);
        check_val("abcd_pp_count", pp_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < pp_log.size()) check_val("abcd_pp", pp_log[i], abcd_pp[i]);
        end
        check_val("abcd_acc", acc, 16'h88EF);

        // Widest nibble products
        run_op(8'hFF, 8'hFF, 5);
        check_val("ffff_pp_count", pp_log.size(), 4);
        foreach (pp_log[i]) check_val("ffff_pp", pp_log[i][9:2], 8'hE1);
        check_val("ffff_acc", acc, 16'hFE01);

        // Operands change and start re-pulses while busy
        c0 = clr_cnt;
        d0 = done_cnt;
        @(negedge clk);
        a = 8'h5A;
        b = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            a = 8'h00;
            b = 8'h00;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("busy_clr_count", clr_cnt - c0, 1);
        check_val("busy_done_count", done_cnt - d0, 1);
        check_val("busy_acc", acc, 16'h448E);

        // start held high for 20 edges: accepted at edges 0, 7 and 14
        c0 = clr_cnt;
        d0 = done_cnt;
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("held_done_count", done_cnt - d0, 3);
        check_val("held_clr_count", clr_cnt - c0, 3);
        check_val("held_acc", acc, 16'h03A8);

        // Reset in LH, then a clean run
        @(negedge clk);
        a = 8'hAB;
        b = 8'hCD;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (state_out != 3'd3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val("reached_lh", state_out, 3);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_reset_outputs",
                  {pp_out, shift_ctrl, acc_clr, acc_en, busy, done, state_out}, 0);
        rst = 1'b0;
        run_op(8'hAB, 8'hCD, 5);
        check_val("after_reset_acc", acc, 16'h88EF);

        // Zero nibbles / zero operand
        run_op(8'h0F, 8'h0F, SKIP ? 2 : 5);
        check_val("0f0f_acc", acc, 16'h00E1);
        check_val("0f0f_pp_count", pp_log.size(), SKIP ? 1 : 4);
        if (pp_log.size() > 0) check_val("0f0f_first_pp", pp_log[0], {8'hE1, 2'b00});
        run_op(8'h00, 8'h5A, SKIP ? 1 : 5);
        check_val("zero_acc", acc, 16'h0000);
        check_val("zero_pp_count", pp_log.size(), SKIP ? 0 : 4);

        repeat (3) @(negedge clk);
        check_val("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
